// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: turns one unsigned intensity sample into a deterministic
// spike train over WINDOW clock cycles using a first-order sigma-delta
// (phase accumulator). Spikes per window = floor(intensity*WINDOW/2^DATA_W).
// Samples arrive on a valid/ready handshake and consecutive windows can be
// streamed with no idle gap between them.
module spike_rate_encoder #(
    parameter  int DATA_W = 8,
    parameter  int WINDOW = 256,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_intensity,
    input  logic              flush,
    output logic              spike_out,
    output logic              busy,
    output logic              window_done,
    output logic [CNT_W-1:0]  spike_count
);

    typedef enum logic {
        IDLE,
        ENCODE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WINDOW - 1);

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] intensity_q;
    logic [CNT_W-1:0]  step_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic [DATA_W:0]   sum;
    logic              spike;
    logic              last_step;
    logic              accept;

    // Accumulator step: the carry out of the DATA_W-bit add is the spike.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, intensity_q};
        spike = sum[DATA_W];
    end

    // Handshake: open in IDLE and on the final step of a window, so the next
    // sample can be taken without a bubble. Reset and flush both close it.
    always_comb begin
        last_step = (state == ENCODE) && (step_cnt == LAST_STEP);
        in_ready  = !reset && !flush && ((state == IDLE) || last_step);
        accept    = in_valid && in_ready;
    end

    assign busy = (state == ENCODE);

    // Encoder state, accumulator, step counter and registered outputs.
    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other; mixing in = would make results depend
    // on statement order and break the one-step-per-edge timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            intensity_q <= '0;
            step_cnt    <= '0;
            run_cnt     <= '0;
            spike_out   <= 1'b0;
            window_done <= 1'b0;
            spike_count <= '0;
        end else if (flush) begin
            // Abort: drop the window silently, keep the last completed count.
            state       <= IDLE;
            acc         <= '0;
            step_cnt    <= '0;
            run_cnt     <= '0;
            spike_out   <= 1'b0;
            window_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    spike_out   <= 1'b0;
                    window_done <= 1'b0;
                    if (accept) begin
                        intensity_q <= in_intensity;
                        acc         <= '0;
                        step_cnt    <= '0;
                        state       <= ENCODE;
                    end
                end
                ENCODE: begin
                    spike_out <= spike;
                    acc       <= sum[DATA_W-1:0];
                    if (last_step) begin
                        window_done <= 1'b1;
                        spike_count <= run_cnt + CNT_W'(spike);
                        run_cnt     <= '0;
                        step_cnt    <= '0;
                        if (accept) begin
                            // Chain straight into the next window.
                            intensity_q <= in_intensity;
                            acc         <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        window_done <= 1'b0;
                        step_cnt    <= step_cnt + CNT_W'(1);
                        run_cnt     <= run_cnt + CNT_W'(spike);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Upstream stage of lif_neuron. Converts one unsigned intensity sample into a deterministic binary spike train over a fixed window of WINDOW clock cycles.
- Encoding is a first-order sigma-delta (phase accumulator), so spike count per window = floor(intensity*WINDOW/2^DATA_W).
- spike_out drives lif_neuron.binary_input directly.
- Samples arrive over a valid/ready handshake, and back-to-back windows stream with no gap.

Parameters:
- DATA_W, 8, intensity width; accumulator modulus is 2^DATA_W.
- WINDOW, 256, encode steps per sample; legal range >= 2.
- CNT_W, $clog2(WINDOW+1), width of spike_count (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  intensity sample offered.
- in_ready  output  1  encoder can accept a sample this cycle.
- in_intensity  input  DATA_W  unsigned sample; sampled only on accept.
- flush  input  1  synchronous abort of current window.
- spike_out  output  1  registered spike train to neuron.
- busy  output  1  high while state==ENCODE.
- window_done  output  1  one-cycle pulse coincident with final step's spike_out.
- spike_count  output  CNT_W  spikes emitted in last completed window.

Behaviour:
- Reset (async, active-high): state=IDLE, acc=0, step_cnt=0, intensity reg=0, spike_out=0, window_done=0, spike_count=0, busy=0. in_ready is forced 0 while reset is high. All outputs go to reset values immediately, including mid-window.
- States:
  - IDLE: in_ready=1 (when flush=0). Accept (in_valid&&in_ready) -> latch intensity, acc<=0, step_cnt<=0, go to ENCODE. spike_out<=0.
  - ENCODE: each edge performs one step.
- Step arithmetic: sum = acc + intensity (DATA_W+1 bits). spike_out<=sum[DATA_W]. acc<=sum[DATA_W-1:0]. step_cnt<=step_cnt+1. Running counter adds the spike.
- Latency: accept at edge E0; step i result is driven on spike_out from edge Ei to Ei+1 (i=1..WINDOW).
- Last step (step_cnt==WINDOW-1 before the edge):
  - spike_count <= running count including the last spike.
  - window_done asserted for the cycle after EWINDOW.
  - Running counter clears.
- in_ready in ENCODE is 1 only in the cycle where step_cnt==WINDOW-1.
  - If accepted: the new sample is latched, acc<=0, step_cnt<=0, state stays ENCODE; next step's spike follows with no idle gap.
  - If not accepted: state -> IDLE; spike_out returns to 0 one edge later.
- Intensity 0: no spikes, window_done still pulses, spike_count=0.
- Intensity 2^DATA_W-1 with WINDOW=2^DATA_W: step1 has no spike, every later step spikes; count=WINDOW-1.
- flush (sync):
  - Effect: state<=IDLE, spike_out<=0, acc<=0, step_cnt<=0, running count<=0.
  - No window_done; spike_count keeps its previous value.
  - flush forces in_ready=0, so flush wins over a simultaneous accept.
  - flush in IDLE has no effect beyond blocking accept.
- in_valid without in_ready: sample not consumed, no state change.
- busy = (state==ENCODE).

Test Plan:
1. Defaults, reset released, accept intensity 128 -> spike_out 0,1,0,1... for steps 1..256 (first 1 at step 2); window_done single pulse at step 256; spike_count=128; IDLE and in_ready=1 after.
2. Intensity 1 then intensity 0 (separate windows) -> one spike exactly at step 256 and count=1; then zero spikes, window_done still pulses, count=0.
3. Intensity 255 -> step1=0, steps 2..256 all 1; spike_count=255.
4. in_valid held high with 64 then 192 -> in_ready high only at step 256 of first window; second window's step1 immediately follows with no gap; counts read 64 then 192; busy never drops.
5. Intensity 200, flush at step 100 with in_valid also high -> spike_out 0 next cycle, no window_done, spike_count unchanged, not accepted, state IDLE, in_ready=1 next cycle.
6. Async reset asserted mid-window between clock edges -> spike_out, busy, window_done, spike_count go to 0 without a clock edge; in_ready=0 during reset; clean 128 window after release matches scenario 1.
